// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO, first-word-fall-through: a written byte is visible one cycle later.
// Input side never stalls (bytes are dropped when full, sticky overflow); output side is valid/ready; break flushes.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  in_break,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  out_break,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   lvl;
  logic                  full;
  logic                  read;
  logic                  write;

  assign in_ready  = 1'b1;
  assign out_valid = (lvl != '0);
  assign full      = (lvl == FULL_LVL);
  assign read      = out_valid && out_ready;
  // A read in the same cycle frees a slot, so a full FIFO still accepts the byte.
  assign write     = in_valid && (!full || read);
  assign out_data  = mem[rd_ptr];
  assign level     = lvl;

  always_ff @(posedge clk) begin
    if (write && !in_break) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lvl       <= '0;
      overflow  <= 1'b0;
      out_break <= 1'b0;
    end else begin
      out_break <= in_break;
      // Break outranks any read or write presented in the same cycle.
      if (in_break) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        lvl      <= '0;
        overflow <= 1'b0;
      end else begin
        if (write) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (read) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (write && !read) begin
          lvl <= lvl + 1'b1;
        end else if (read && !write) begin
          lvl <= lvl - 1'b1;
        end
        if (in_valid && !write) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at DEPTH=16: vector table plus multi-cycle corner sequences.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       in_break;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       out_break;
  logic       overflow;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .in_break(in_break), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .out_break(out_break),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       brk;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic [4:0] e_level;
    logic       e_ovf;
    logic       e_brk;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive at a falling edge, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic iv, input logic [7:0] d, input logic brk, input logic rdy);
    in_valid  = iv;
    in_data   = d;
    in_break  = brk;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic brk,
                              input logic rdy, input logic ev, input logic [7:0] ed,
                              input logic [4:0] el, input logic eo, input logic eb);
    vec_t v;
    v.iv = iv; v.d = d; v.brk = brk; v.rdy = rdy;
    v.e_valid = ev; v.e_data = ed; v.e_level = el; v.e_ovf = eo; v.e_brk = eb;
    return v;
  endfunction

  initial begin
    logic [7:0] got [$];
    int         max_lvl;

    vecs[0] = mk(1, 8'hA5, 0, 0, 1, 8'hA5, 5'd1, 0, 0);
    vecs[1] = mk(0, 8'h00, 0, 0, 1, 8'hA5, 5'd1, 0, 0);
    vecs[2] = mk(1, 8'h3C, 0, 1, 1, 8'h3C, 5'd1, 0, 0);
    vecs[3] = mk(0, 8'h00, 0, 1, 0, 8'h00, 5'd0, 0, 0);
    vecs[4] = mk(0, 8'h00, 0, 1, 0, 8'h00, 5'd0, 0, 0);
    vecs[5] = mk(1, 8'h11, 0, 0, 1, 8'h11, 5'd1, 0, 0);
    vecs[6] = mk(1, 8'h22, 0, 0, 1, 8'h11, 5'd2, 0, 0);
    vecs[7] = mk(1, 8'h33, 1, 1, 0, 8'h00, 5'd0, 0, 1);
    vecs[8] = mk(1, 8'h01, 0, 0, 1, 8'h01, 5'd1, 0, 0);
    vecs[9] = mk(0, 8'h00, 0, 1, 0, 8'h00, 5'd0, 0, 0);

    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_break = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    step(1, 8'h99, 0, 0);
    step(1, 8'h98, 0, 0);
    chk("pre_reset_level", level, 2);
    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 resetn = 1'b0;
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_level", level, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_brk", out_break, 0);
    chk("in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    chk("post_release_level", level, 0);

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].brk, vecs[i].rdy);
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
      chk($sformatf("vec%0d_level", i), level, vecs[i].e_level);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].e_ovf);
      chk($sformatf("vec%0d_brk", i), out_break, vecs[i].e_brk);
    end

    // Ordering and wrap with the consumer always ready.
    max_lvl = 0;
    for (int i = 0; i < 41; i++) begin
      if (out_valid) got.push_back(out_data);
      step(i < 40, 8'(i), 0, 1);
      if (int'(level) > max_lvl) max_lvl = int'(level);
    end
    chk("wrap_count", got.size(), 40);
    for (int i = 0; i < got.size() && i < 40; i++) chk($sformatf("wrap_byte%0d", i), got[i], i);
    chk("wrap_max_level", max_lvl, 1);
    chk("wrap_ovf", overflow, 0);

    // Fill past full, then drain.
    for (int i = 0; i < 18; i++) step(1, 8'(8'h10 + i), 0, 0);
    chk("full_level", level, 16);
    chk("full_ovf", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_byte%0d", i), out_valid ? int'(out_data) : -1, 8'h10 + i);
      step(0, 8'h00, 0, 1);
    end
    chk("drain_empty", out_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);

    // Held break of three cycles clears overflow; out_break follows one cycle late.
    chk("hbrk_pre", out_break, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, i < 3, 0);
      chk($sformatf("hbrk_cycle%0d", i), out_break, i < 3);
      if (i == 0) chk("hbrk_ovf_clear", overflow, 0);
    end

    // Simultaneous read and write while full.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h80 + i), 0, 0);
    chk("rw_full_level", level, 16);
    step(1, 8'h55, 0, 1);
    chk("rw_level", level, 16);
    chk("rw_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rw_byte%0d", i), out_valid ? int'(out_data) : -1,
          (i < 15) ? 8'h81 + i : 8'h55);
      step(0, 8'h00, 0, 1);
    end
    chk("rw_empty", out_valid, 0);

    // Break with five bytes buffered, concurrent write and ready.
    for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), 0, 0);
    chk("mbrk_pre_level", level, 5);
    step(1, 8'h77, 1, 1);
    chk("mbrk_brk", out_break, 1);
    chk("mbrk_level", level, 0);
    chk("mbrk_valid", out_valid, 0);
    chk("mbrk_ovf", overflow, 0);
    step(1, 8'h01, 0, 0);
    chk("mbrk_next_valid", out_valid, 1);
    chk("mbrk_next_data", out_data, 8'h01);
    chk("mbrk_next_level", level, 1);
    step(0, 8'h00, 0, 1);
    chk("mbrk_final_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
